// File: rtl/ripple_count_sampler.sv
// ---------------------------------------------------------------------------
// ripple_count_sampler
//
// Purpose:
//   This block samples the raw outputs of an asynchronous ripple counter in
//   the clk domain. Each bit passes through a two-flop synchroniser. A
//   stability filter then discards the transient codes that appear while the
//   ripple counter settles. Each settled count change becomes one record
//   {wrap, data} in a small FIFO, which a consumer drains over valid/ready.
//
// Parameters:
//   WIDTH  - counter width sampled
//   STABLE - consecutive identical synchronised samples needed (1..15)
//   DEPTH  - FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk        in   sampling clock, rising edge
//   reset      in   asynchronous active-low reset
//   q_in       in   [WIDTH]  raw ripple counter bits (asynchronous)
//   out_valid  out  FIFO head valid
//   out_ready  in   consumer accepts head
//   out_data   out  [WIDTH]  head record count value
//   out_wrap   out  head record wrap flag
//   level      out  [clog2(DEPTH)+1]  FIFO occupancy
//   overflow   out  sticky flag: a record was dropped
//   ovf_clr    in   synchronous clear of overflow
//   value      out  [WIDTH]  current settled count
//   wrap_count out  [8]  accepted wraps (only with RIPPLE_SAMPLER_WRAPCNT_EN)
//
// Optional feature macro: RIPPLE_SAMPLER_WRAPCNT_EN
// ---------------------------------------------------------------------------
module ripple_count_sampler #(
  parameter int WIDTH  = 4,
  parameter int STABLE = 2,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           q_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_wrap,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  input  logic                       ovf_clr,
  output logic [WIDTH-1:0]           value
`ifdef RIPPLE_SAMPLER_WRAPCNT_EN
  ,
  output logic [7:0]                 wrap_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_cand;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_value;

  logic [WIDTH:0]   r_mem [DEPTH];
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [LW-1:0]    r_level;
  logic [WIDTH:0]   r_hold;
  logic             r_ovf;

  logic             w_accept;
  logic             w_wrap;
  logic             w_full;
  logic             w_pop;
  logic             w_write;
  logic             w_drop;
  logic [WIDTH:0]   w_head;

  // Accept decision. When STABLE > 1, a value is accepted on the edge where
  // the candidate reaches its STABLE-th matching sample. This fires only
  // once per candidate, so a long-held value cannot be pushed twice. When
  // STABLE is 1, any synchronised change is accepted directly. In both
  // cases the accepted code equals r_s2.
  always_comb begin
    w_accept = 1'b0;
    if (STABLE == 1) begin
      w_accept = (r_s2 != r_value);
    end else begin
      w_accept = (r_s2 == r_cand) &&
                 (({1'b0, r_cnt} + 5'd1) == 5'(STABLE)) &&
                 (r_cand != r_value);
    end
  end

  // A record is a wrap when the new count is below the old one.
  assign w_wrap  = (r_s2 < r_value);

  assign w_full  = (r_level == LW'(DEPTH));
  assign w_pop   = (r_level != '0) && out_ready;
  // When the FIFO is full, a push still lands if the head leaves on the same edge.
  assign w_write = w_accept && (!w_full || w_pop);
  assign w_drop  = w_accept && w_full && !w_pop;
  assign w_head  = r_mem[r_rdPtr];

  // Synchroniser, stability filter and settled value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_cand  <= '0;
      r_cnt   <= 4'(STABLE);
      r_value <= '0;
    end else begin
      r_s1 <= q_in;
      r_s2 <= r_s1;
      if (r_s2 != r_cand) begin
        r_cand <= r_s2;
        r_cnt  <= 4'd1;
      end else if (r_cnt < 4'(STABLE)) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (w_accept) begin
        r_value <= r_s2;
      end
    end
  end

  // FIFO storage, pointers and occupancy. On reset, the contents are cleared
  // so that the head reads as zero until the first push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_write) begin
        r_mem[r_wrPtr] <= {w_wrap, r_s2};
        r_wrPtr        <= r_wrPtr + PW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      case ({w_write, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // r_hold tracks the head while the FIFO is non-empty. After the FIFO
  // drains, the outputs keep showing the last record instead of a stale slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold <= '0;
    end else if (r_level != '0) begin
      r_hold <= w_head;
    end
  end

  // Sticky overflow. A drop on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

`ifdef RIPPLE_SAMPLER_WRAPCNT_EN
  logic [7:0] r_wrapCnt;

  // Counts every accepted wrap, including wraps whose record was dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrapCnt <= '0;
    end else if (w_accept && w_wrap) begin
      r_wrapCnt <= r_wrapCnt + 8'd1;
    end
  end

  assign wrap_count = r_wrapCnt;
`endif

  assign out_valid = (r_level != '0);
  assign out_data  = out_valid ? w_head[WIDTH-1:0] : r_hold[WIDTH-1:0];
  assign out_wrap  = out_valid ? w_head[WIDTH]     : r_hold[WIDTH];
  assign level     = r_level;
  assign overflow  = r_ovf;
  assign value     = r_value;

endmodule

// File: tb/tb_ripple_count_sampler.sv
// ---------------------------------------------------------------------------
// tb_ripple_count_sampler
//
// Purpose:
//   Directed self-checking bench for ripple_count_sampler with default
//   parameters (WIDTH=4, STABLE=2, DEPTH=4). Inputs change on the falling
//   edge, and outputs are checked on the falling edge. Expected values are
//   hand-derived. A q_in change made at a falling edge settles into value
//   after the 4th following rising edge.
//   The wrap_count checks are compiled in only when the
//   RIPPLE_SAMPLER_WRAPCNT_EN macro is defined.
// ---------------------------------------------------------------------------
module tb_ripple_count_sampler;

  logic       clk;
  logic       reset;
  logic [3:0] q_in;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_wrap;
  logic [2:0] level;
  logic       overflow;
  logic       ovf_clr;
  logic [3:0] value;
`ifdef RIPPLE_SAMPLER_WRAPCNT_EN
  logic [7:0] wrap_count;
`endif

  int numChecks = 0;
  int numFails  = 0;

  ripple_count_sampler #(
    .WIDTH(4),
    .STABLE(2),
    .DEPTH(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .q_in      (q_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_wrap  (out_wrap),
    .level     (level),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .value     (value)
`ifdef RIPPLE_SAMPLER_WRAPCNT_EN
    ,
    .wrap_count(wrap_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then return at the following falling edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Drive the data inputs. The caller is at a falling edge.
  task automatic applyStimulus(input logic [3:0] q, input logic rdy, input logic clr);
    q_in      = q;
    out_ready = rdy;
    ovf_clr   = clr;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    numChecks++;
    assert (obs === exp) else begin
      numFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold q for six cycles with no pop. This is long enough for the value to settle.
  task automatic settle(input logic [3:0] q);
    applyStimulus(q, 1'b0, 1'b0);
    tick(6);
  endtask

  // Pop exactly one record.
  task automatic popOne();
    applyStimulus(q_in, 1'b1, 1'b0);
    tick(1);
    applyStimulus(q_in, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(4'd0, 1'b0, 1'b0);
    tick(2);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_value", 32'(value), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    checkOutput("rst_data", 32'(out_data), 32'd0);
    checkOutput("rst_wrap", 32'(out_wrap), 32'd0);
    reset = 1'b1;

    // Idle with q_in=0 for 10 cycles.
    tick(10);
    checkOutput("idle_valid", 32'(out_valid), 32'd0);
    checkOutput("idle_value", 32'(value), 32'd0);
    checkOutput("idle_level", 32'(level), 32'd0);
    checkOutput("idle_ovf", 32'(overflow), 32'd0);

    // 0 -> 5: not yet visible after edge 3, visible after edge 4.
    applyStimulus(4'd5, 1'b0, 1'b0);
    tick(3);
    checkOutput("lat_e3_value", 32'(value), 32'd0);
    checkOutput("lat_e3_valid", 32'(out_valid), 32'd0);
    tick(1);
    checkOutput("lat_e4_value", 32'(value), 32'd5);
    checkOutput("lat_e4_valid", 32'(out_valid), 32'd1);
    checkOutput("lat_e4_data", 32'(out_data), 32'd5);
    checkOutput("lat_e4_wrap", 32'(out_wrap), 32'd0);
    checkOutput("lat_e4_level", 32'(level), 32'd1);

    // One-cycle glitch to 7 must be filtered.
    applyStimulus(4'd7, 1'b0, 1'b0);
    tick(1);
    applyStimulus(4'd5, 1'b0, 1'b0);
    tick(6);
    checkOutput("glitch_value", 32'(value), 32'd5);
    checkOutput("glitch_level", 32'(level), 32'd1);

    // Drain, then check that the outputs hold the last record while empty.
    popOne();
    checkOutput("pop5_valid", 32'(out_valid), 32'd0);
    checkOutput("pop5_level", 32'(level), 32'd0);
    checkOutput("pop5_hold", 32'(out_data), 32'd5);

    // out_ready while empty is ignored.
    popOne();
    checkOutput("empty_rdy_level", 32'(level), 32'd0);

    // 15 then 0: the second record is a wrap.
    settle(4'd15);
    checkOutput("v15_value", 32'(value), 32'd15);
    checkOutput("v15_data", 32'(out_data), 32'd15);
    checkOutput("v15_wrap", 32'(out_wrap), 32'd0);
    popOne();
    settle(4'd0);
    checkOutput("v0_value", 32'(value), 32'd0);
    checkOutput("v0_data", 32'(out_data), 32'd0);
    checkOutput("v0_wrap", 32'(out_wrap), 32'd1);
`ifdef RIPPLE_SAMPLER_WRAPCNT_EN
    checkOutput("wrapcnt_1", 32'(wrap_count), 32'd1);
`endif
    popOne();
    checkOutput("v0_pop_level", 32'(level), 32'd0);

    // Five pushes with no pop: the fifth push (6) is dropped.
    settle(4'd1);
    settle(4'd2);
    settle(4'd3);
    settle(4'd4);
    checkOutput("fill_level4", 32'(level), 32'd4);
    checkOutput("fill_ovf0", 32'(overflow), 32'd0);
    settle(4'd6);
    checkOutput("ovf_level", 32'(level), 32'd4);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    checkOutput("ovf_value", 32'(value), 32'd6);
    checkOutput("ovf_head", 32'(out_data), 32'd1);
    popOne();
    checkOutput("drain_head2", 32'(out_data), 32'd2);
    popOne();
    checkOutput("drain_head3", 32'(out_data), 32'd3);
    popOne();
    checkOutput("drain_head4", 32'(out_data), 32'd4);
    popOne();
    checkOutput("drain_level", 32'(level), 32'd0);
    checkOutput("drain_ovf_sticky", 32'(overflow), 32'd1);
    applyStimulus(q_in, 1'b0, 1'b1);
    tick(1);
    applyStimulus(q_in, 1'b0, 1'b0);
    checkOutput("ovf_cleared", 32'(overflow), 32'd0);

    // Fill with 7..10, then push 11 on the same edge as a pop.
    settle(4'd7);
    settle(4'd8);
    settle(4'd9);
    settle(4'd10);
    checkOutput("full2_level", 32'(level), 32'd4);
    applyStimulus(4'd11, 1'b0, 1'b0);
    tick(3);
    applyStimulus(4'd11, 1'b1, 1'b0);
    tick(1);
    applyStimulus(4'd11, 1'b0, 1'b0);
    checkOutput("pushpop_level", 32'(level), 32'd4);
    checkOutput("pushpop_ovf", 32'(overflow), 32'd0);
    checkOutput("pushpop_value", 32'(value), 32'd11);
    checkOutput("pushpop_head", 32'(out_data), 32'd8);

    // Asynchronous reset mid-stream takes effect without a clock edge.
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_level", 32'(level), 32'd0);
    checkOutput("midrst_value", 32'(value), 32'd0);
    checkOutput("midrst_data", 32'(out_data), 32'd0);
`ifdef RIPPLE_SAMPLER_WRAPCNT_EN
    checkOutput("midrst_wrapcnt", 32'(wrap_count), 32'd0);
`endif
    tick(1);
    reset = 1'b1;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
